// File: rtl/sobel_pkg.sv
// Shared constants for the oriented Sobel engine: output modes, direction codes
// and the four 3x3 kernels (index k = row*3 + col).
package sobel_pkg;

  localparam logic [1:0] MODE_L2   = 2'd0;
  localparam logic [1:0] MODE_MAXO = 2'd1;
  localparam logic [1:0] MODE_GRAY = 2'd2;
  localparam logic [1:0] MODE_DIR  = 2'd3;

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  typedef logic signed [2:0] coef_t;

  localparam coef_t K_G0 [9] = '{
    -3'sd1, 3'sd0, 3'sd1,
    -3'sd2, 3'sd0, 3'sd2,
    -3'sd1, 3'sd0, 3'sd1
  };

  localparam coef_t K_G45 [9] = '{
     3'sd0,  3'sd1, 3'sd2,
    -3'sd1,  3'sd0, 3'sd1,
    -3'sd2, -3'sd1, 3'sd0
  };

  localparam coef_t K_G90 [9] = '{
    -3'sd1, -3'sd2, -3'sd1,
     3'sd0,  3'sd0,  3'sd0,
     3'sd1,  3'sd2,  3'sd1
  };

  localparam coef_t K_G135 [9] = '{
    -3'sd2, -3'sd1, 3'sd0,
    -3'sd1,  3'sd0, 3'sd1,
     3'sd0,  3'sd1, 3'sd2
  };

endpackage

// File: rtl/sobel_grad3x3.sv
// Combinational signed 3x3 dot product of an unsigned pixel window with one
// fixed Sobel kernel chosen by KSEL (a direction code).
module sobel_grad3x3
  import sobel_pkg::*;
#(
  parameter int         DW   = 8,
  parameter logic [1:0] KSEL = DIR_0
) (
  input  logic [9*DW-1:0]       win,
  output logic signed [DW+2:0]  grad
);

  localparam int GW = DW + 3;

  logic signed [GW-1:0] term [9];

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
      localparam coef_t COEF = (KSEL == DIR_0)  ? K_G0[gi]  :
                               (KSEL == DIR_45) ? K_G45[gi] :
                               (KSEL == DIR_90) ? K_G90[gi] : K_G135[gi];
      logic signed [GW-1:0] pix;
      logic signed [GW-1:0] coef_ext;
      // Zero-extend the pixel, sign-extend the coefficient; the final sum fits GW.
      assign pix      = signed'(GW'(win[gi*DW +: DW]));
      assign coef_ext = GW'(COEF);
      assign term[gi] = pix * coef_ext;
    end
  endgenerate

  always_comb begin
    grad = '0;
    for (int k = 0; k < 9; k++) begin
      grad = grad + term[k];
    end
  end

endmodule

// File: rtl/sobel_oriented_edge.sv
// Three-stage, globally stalled Sobel engine with four orientations, mode-
// selectable output pixel and a per-frame edge-pixel counter.
module sobel_oriented_edge
  import sobel_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [9*DW-1:0]   i_data,
  input  logic              i_sof,
  input  logic [1:0]        i_mode,
  input  logic [2*DW+4:0]   i_threshold,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DW-1:0]     o_data,
  output logic [1:0]        o_dir,
  output logic              o_sof,
  output logic [CW-1:0]     o_edge_cnt
);

  localparam int GW = DW + 3;
  localparam int SW = 2*DW + 5;
  localparam int AW = DW + 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic ce;
  assign ce      = ~o_valid | o_ready;
  assign i_ready = ce;

  logic signed [GW-1:0] grad_c [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_kernel
      sobel_grad3x3 #(
        .DW   (DW),
        .KSEL (2'(gi))
      ) u_grad (
        .win  (i_data),
        .grad (grad_c[gi])
      );
    end
  endgenerate

  // Stage 1: gradients and captured sideband
  logic                 s1_valid_reg;
  logic signed [GW-1:0] s1_grad_reg [4];
  logic [1:0]           s1_mode_reg;
  logic [SW-1:0]        s1_thr_reg;
  logic                 s1_sof_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_reg <= 1'b0;
      for (int k = 0; k < 4; k++) s1_grad_reg[k] <= '0;
      s1_mode_reg  <= '0;
      s1_thr_reg   <= '0;
      s1_sof_reg   <= 1'b0;
    end else if (ce) begin
      s1_valid_reg <= i_valid;
      for (int k = 0; k < 4; k++) s1_grad_reg[k] <= grad_c[k];
      s1_mode_reg  <= i_mode;
      s1_thr_reg   <= i_threshold;
      s1_sof_reg   <= i_sof & i_valid;
    end
  end

  logic [AW-1:0] abs_c [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      abs_c[k] = s1_grad_reg[k][GW-1] ? AW'(-s1_grad_reg[k]) : AW'(s1_grad_reg[k]);
    end
  end

  // Stage 2: magnitudes and squares of the horizontal/vertical gradients
  logic          s2_valid_reg;
  logic [AW-1:0] s2_abs_reg [4];
  logic [SW-1:0] s2_sq0_reg;
  logic [SW-1:0] s2_sq90_reg;
  logic [1:0]    s2_mode_reg;
  logic [SW-1:0] s2_thr_reg;
  logic          s2_sof_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_valid_reg <= 1'b0;
      for (int k = 0; k < 4; k++) s2_abs_reg[k] <= '0;
      s2_sq0_reg   <= '0;
      s2_sq90_reg  <= '0;
      s2_mode_reg  <= '0;
      s2_thr_reg   <= '0;
      s2_sof_reg   <= 1'b0;
    end else if (ce) begin
      s2_valid_reg <= s1_valid_reg;
      for (int k = 0; k < 4; k++) s2_abs_reg[k] <= abs_c[k];
      s2_sq0_reg   <= SW'(abs_c[0]) * SW'(abs_c[0]);
      s2_sq90_reg  <= SW'(abs_c[2]) * SW'(abs_c[2]);
      s2_mode_reg  <= s1_mode_reg;
      s2_thr_reg   <= s1_thr_reg;
      s2_sof_reg   <= s1_sof_reg;
    end
  end

  logic [SW-1:0] m2_c;
  logic [AW-1:0] best_c;
  logic [1:0]    dir_c;
  logic          edge_c;
  logic [DW-1:0] data_c;

  always_comb begin
    m2_c   = s2_sq0_reg + s2_sq90_reg;
    best_c = s2_abs_reg[0];
    dir_c  = DIR_0;
    // Strict compare so that ties keep the lowest direction code.
    for (int k = 1; k < 4; k++) begin
      if (s2_abs_reg[k] > best_c) begin
        best_c = s2_abs_reg[k];
        dir_c  = 2'(k);
      end
    end
    if (s2_mode_reg == MODE_L2) edge_c = (m2_c > s2_thr_reg);
    else                        edge_c = (SW'(best_c) > s2_thr_reg);
    case (s2_mode_reg)
      MODE_GRAY: data_c = (|best_c[AW-1:DW]) ? '1 : best_c[DW-1:0];
      MODE_DIR:  data_c = edge_c ? DW'(dir_c) : '0;
      default:   data_c = edge_c ? '1 : '0;
    endcase
  end

  // Stage 3: output register
  logic edge_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_dir    <= '0;
      o_sof    <= 1'b0;
      edge_reg <= 1'b0;
    end else if (ce) begin
      o_valid  <= s2_valid_reg;
      o_data   <= data_c;
      o_dir    <= dir_c;
      o_sof    <= s2_sof_reg;
      edge_reg <= edge_c;
    end
  end

  logic [CW-1:0] cnt_reg;
  assign o_edge_cnt = cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if (o_valid && o_ready) begin
      if (o_sof)                     cnt_reg <= CW'(edge_reg);
      else if (cnt_reg != CNT_MAX)   cnt_reg <= cnt_reg + CW'(edge_reg);
    end
  end

endmodule

// File: tb/tb_sobel_oriented_edge.sv
// Directed bench for sobel_oriented_edge: hand-computed windows per mode,
// streaming with random back-pressure, frame counting and reset under stall.
module tb_sobel_oriented_edge;

  localparam int DW = 8;
  localparam int CW = 20;
  localparam int SW = 2*DW + 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [9*DW-1:0]   i_data = '0;
  logic              i_sof = 1'b0;
  logic [1:0]        i_mode = 2'd0;
  logic [SW-1:0]     i_threshold = '0;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [DW-1:0]     o_data;
  logic [1:0]        o_dir;
  logic              o_sof;
  logic [CW-1:0]     o_edge_cnt;

  int checks = 0;
  int failures = 0;

  sobel_oriented_edge #(.DW(DW), .CW(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .i_sof       (i_sof),
    .i_mode      (i_mode),
    .i_threshold (i_threshold),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_dir       (o_dir),
    .o_sof       (o_sof),
    .o_edge_cnt  (o_edge_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9*DW-1:0] mkwin(input int a, input int b, input int c,
                                            input int d, input int e, input int f,
                                            input int g, input int h, input int i);
    logic [9*DW-1:0] w;
    int p [9];
    p = '{a, b, c, d, e, f, g, h, i};
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(p[k]);
    return w;
  endfunction

  // Sends one beat into an idle pipeline and waits (bounded) for o_valid.
  task automatic run_one(input logic [9*DW-1:0] w, input logic [1:0] m,
                         input logic [SW-1:0] thr, input logic sof, output int lat);
    @(posedge CLK); #1;
    i_valid = 1'b1; i_data = w; i_mode = m; i_threshold = thr; i_sof = sof; o_ready = 1'b1;
    @(posedge CLK); #1;
    i_valid = 1'b0; i_sof = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b expected=0", o_valid); end
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_o_data got=%h expected=00", o_data); end
    checks++; if (o_dir !== 2'd0) begin failures++; $display("FAIL reset_o_dir got=%0d expected=0", o_dir); end
    checks++; if (o_sof !== 1'b0) begin failures++; $display("FAIL reset_o_sof got=%b expected=0", o_sof); end
    checks++; if (o_edge_cnt !== 20'd0) begin failures++; $display("FAIL reset_cnt got=%0d expected=0", o_edge_cnt); end
    RST = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL reset_i_ready got=%b expected=1", i_ready); end
    $display("test_reset done");
  endtask

  task automatic test_flat();
    int lat;
    run_one(mkwin(100,100,100,100,100,100,100,100,100), 2'd0, 21'd0, 1'b0, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL flat_latency got=%0d expected=3", lat); end
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL flat_data got=%h expected=00", o_data); end
    checks++; if (o_dir !== 2'd0) begin failures++; $display("FAIL flat_dir got=%0d expected=0", o_dir); end
    $display("test_flat lat=%0d data=%h dir=%0d", lat, o_data, o_dir);
  endtask

  task automatic test_step_l2();
    int lat;
    // G0 = 1020, G90 = 0 -> M2 = 1040400
    run_one(mkwin(0,0,255,0,0,255,0,0,255), 2'd0, 21'd1040399, 1'b0, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL step_latency got=%0d expected=3", lat); end
    checks++; if (o_data !== 8'hFF) begin failures++; $display("FAIL step_l2_data got=%h expected=ff", o_data); end
    checks++; if (o_dir !== 2'd0) begin failures++; $display("FAIL step_l2_dir got=%0d expected=0", o_dir); end
    $display("test_step_l2 thr=1040399 data=%h dir=%0d", o_data, o_dir);
    run_one(mkwin(0,0,255,0,0,255,0,0,255), 2'd0, 21'd1040400, 1'b0, lat);
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL step_l2_equal_thr got=%h expected=00", o_data); end
    $display("test_step_l2 thr=1040400 data=%h", o_data);
  endtask

  task automatic test_direction();
    int lat;
    // G0 = 40, G45 = 0, G90 = 40, G135 = 60
    run_one(mkwin(0,0,0,0,0,10,0,10,20), 2'd3, 21'd5, 1'b0, lat);
    checks++; if (o_data !== 8'd3) begin failures++; $display("FAIL dir_data got=%0d expected=3", o_data); end
    checks++; if (o_dir !== 2'd3) begin failures++; $display("FAIL dir_code got=%0d expected=3", o_dir); end
    $display("test_direction thr=5 data=%0d dir=%0d", o_data, o_dir);
    run_one(mkwin(0,0,0,0,0,10,0,10,20), 2'd3, 21'd60, 1'b0, lat);
    checks++; if (o_data !== 8'd0) begin failures++; $display("FAIL dir_no_edge_data got=%0d expected=0", o_data); end
    checks++; if (o_dir !== 2'd3) begin failures++; $display("FAIL dir_no_edge_code got=%0d expected=3", o_dir); end
    $display("test_direction thr=60 data=%0d dir=%0d", o_data, o_dir);
    // G0 = G90 = |G135| = 20, G45 = 0: tie resolves to code 0
    run_one(mkwin(0,0,0,0,0,10,0,10,0), 2'd1, 21'd5, 1'b0, lat);
    checks++; if (o_dir !== 2'd0) begin failures++; $display("FAIL dir_tie got=%0d expected=0", o_dir); end
    checks++; if (o_data !== 8'hFF) begin failures++; $display("FAIL maxo_data got=%h expected=ff", o_data); end
    $display("test_direction tie data=%h dir=%0d", o_data, o_dir);
  endtask

  task automatic test_gray();
    int lat;
    run_one(mkwin(0,0,255,0,0,255,0,0,255), 2'd2, 21'd0, 1'b0, lat);
    checks++; if (o_data !== 8'd255) begin failures++; $display("FAIL gray_sat got=%0d expected=255", o_data); end
    $display("test_gray full step data=%0d", o_data);
    // G0 = 40, G45 = G135 = 30, G90 = 0
    run_one(mkwin(0,0,10,0,0,10,0,0,10), 2'd2, 21'd0, 1'b0, lat);
    checks++; if (o_data !== 8'd40) begin failures++; $display("FAIL gray_40 got=%0d expected=40", o_data); end
    checks++; if (o_dir !== 2'd0) begin failures++; $display("FAIL gray_40_dir got=%0d expected=0", o_dir); end
    $display("test_gray G0=40 data=%0d dir=%0d", o_data, o_dir);
  endtask

  task automatic test_back_to_back();
    logic [9*DW-1:0] w;
    logic [1:0]      modes [3];
    logic [SW-1:0]   thrs  [3];
    logic [DW-1:0]   exp_data [3];
    w = mkwin(0,0,255,0,0,255,0,0,255);
    modes = '{2'd0, 2'd1, 2'd1};
    thrs  = '{21'd0, 21'd1020, 21'd1019};
    exp_data = '{8'hFF, 8'h00, 8'hFF};
    o_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(posedge CLK); #1;
      i_valid = 1'b1; i_data = w; i_mode = modes[b]; i_threshold = thrs[b]; i_sof = 1'b0;
    end
    @(posedge CLK); #1;
    i_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin @(posedge CLK); #1; end
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp_data[b]) begin
        failures++;
        $display("FAIL b2b_beat%0d got valid=%b data=%h expected valid=1 data=%h", b, o_valid, o_data, exp_data[b]);
      end
      $display("test_back_to_back beat=%0d data=%h", b, o_data);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    logic was_stalled = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic [1:0] held_dir = '0;
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(posedge CLK); #1;
      o_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        i_valid = 1'b1;
        i_data = mkwin(0, 0, sent+1, 0, 0, sent+1, 0, 0, sent+1);
        i_mode = 2'd2; i_threshold = 21'd0; i_sof = (sent == 0);
      end else begin
        i_valid = 1'b0; i_sof = 1'b0;
      end
      #1;
      if (was_stalled) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== held_data || o_dir !== held_dir) begin
          failures++;
          $display("FAIL stream_hold got valid=%b data=%h dir=%0d expected valid=1 data=%h dir=%0d",
                   o_valid, o_data, o_dir, held_data, held_dir);
        end
      end
      if (o_valid === 1'b1 && o_ready === 1'b1) begin
        exp = 8'(4 * (got + 1));
        checks++;
        if (o_data !== exp || o_dir !== 2'd0) begin
          failures++;
          $display("FAIL stream_beat%0d got data=%0d dir=%0d expected data=%0d dir=0", got, o_data, o_dir, exp);
        end
        $display("test_stream out=%0d data=%0d", got, o_data);
        got++;
      end
      was_stalled = (o_valid === 1'b1) && !o_ready;
      held_data = o_data;
      held_dir = o_dir;
      if (i_valid && i_ready === 1'b1) sent++;
    end
    i_valid = 1'b0; i_sof = 1'b0;
    checks++; if (got != 20) begin failures++; $display("FAIL stream_count got=%0d expected=20", got); end
    @(posedge CLK); #1;
    o_ready = 1'b1;
    checks++; if (o_edge_cnt !== 20'd20) begin failures++; $display("FAIL stream_cnt got=%0d expected=20", o_edge_cnt); end
    $display("test_stream done received=%0d cnt=%0d", got, o_edge_cnt);
  endtask

  task automatic test_frame_count();
    int lat;
    logic is_edge [6];
    is_edge = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int b = 0; b < 6; b++) begin
      if (is_edge[b]) run_one(mkwin(0,0,255,0,0,255,0,0,255), 2'd0, 21'd0, b == 0, lat);
      else            run_one(mkwin(7,7,7,7,7,7,7,7,7), 2'd0, 21'd0, b == 0, lat);
      checks++;
      if (o_sof !== (b == 0)) begin failures++; $display("FAIL frame_sof beat=%0d got=%b expected=%b", b, o_sof, b == 0); end
      $display("test_frame_count beat=%0d data=%h sof=%b", b, o_data, o_sof);
    end
    @(posedge CLK); #1;
    checks++; if (o_edge_cnt !== 20'd4) begin failures++; $display("FAIL frame_cnt got=%0d expected=4", o_edge_cnt); end
    run_one(mkwin(0,0,255,0,0,255,0,0,255), 2'd0, 21'd0, 1'b1, lat);
    @(posedge CLK); #1;
    checks++; if (o_edge_cnt !== 20'd1) begin failures++; $display("FAIL frame_restart_cnt got=%0d expected=1", o_edge_cnt); end
    $display("test_frame_count cnt=%0d", o_edge_cnt);
  endtask

  task automatic test_reset_mid_stall();
    int lat;
    @(posedge CLK); #1;
    i_valid = 1'b1; i_data = mkwin(0,0,0,0,0,10,0,10,20); i_mode = 2'd3; i_threshold = 21'd5;
    i_sof = 1'b1; o_ready = 1'b0;
    @(posedge CLK); #1;
    i_valid = 1'b0; i_sof = 1'b0;
    for (int c = 0; c < 5; c++) begin @(posedge CLK); #1; end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'd3 || o_dir !== 2'd3 || o_sof !== 1'b1) begin
      failures++;
      $display("FAIL stall_out got valid=%b data=%0d dir=%0d sof=%b expected 1 3 3 1", o_valid, o_data, o_dir, o_sof);
    end
    checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL stall_i_ready got=%b expected=0", i_ready); end
    checks++; if (o_edge_cnt !== 20'd1) begin failures++; $display("FAIL stall_cnt got=%0d expected=1", o_edge_cnt); end
    RST = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'd0 || o_dir !== 2'd0 || o_sof !== 1'b0 || o_edge_cnt !== 20'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%b data=%0d dir=%0d sof=%b cnt=%0d expected all 0",
               o_valid, o_data, o_dir, o_sof, o_edge_cnt);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL post_reset_i_ready got=%b expected=1", i_ready); end
    run_one(mkwin(0,0,255,0,0,255,0,0,255), 2'd0, 21'd0, 1'b0, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL post_reset_latency got=%0d expected=3", lat); end
    @(posedge CLK); #1;
    checks++; if (o_edge_cnt !== 20'd1) begin failures++; $display("FAIL post_reset_cnt got=%0d expected=1", o_edge_cnt); end
    $display("test_reset_mid_stall cnt=%0d", o_edge_cnt);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step_l2();
    test_direction();
    test_gray();
    test_back_to_back();
    test_stream();
    test_frame_count();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
